systolic_row_feeder: RTL and testbench



---
 rtl/systolic_pkg.sv | 14 +
 rtl/systolic_feeder_lane.sv | 54 +++++
 rtl/systolic_row_feeder.sv | 98 +++++++++
 tb/tb_systolic_row_feeder.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared sizing and FSM encoding for the systolic array feeder, the row FIFOs and the PE array.
package systolic_pkg;
    localparam int ROWS      = 32;
    localparam int ROWS_LOG2 = 5;
    localparam int BWIDTH    = 8;
    localparam int KW        = 8;
    localparam int CW        = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } feeder_state_e;
endpackage

// File: rtl/systolic_feeder_lane.sv
// One row of the skewing feeder: decides whether its row is due at schedule step t and
// holds the registered operand/valid pair presented to the west edge of that PE row.
module systolic_feeder_lane
    import systolic_pkg::*;
#(
    parameter int ROW = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              run_i,
    input  logic [CW-1:0]     t_i,
    input  logic [KW-1:0]     k_len_i,
    input  logic              advance_i,
    input  logic              clear_i,
    input  logic [BWIDTH-1:0] dout_i,
    output logic              due_o,
    output logic [BWIDTH-1:0] pe_a_o,
    output logic              pe_valid_o
);
    localparam logic [CW-1:0] ROW_C = CW'(ROW);

    logic [CW-1:0]     end_excl;
    logic [BWIDTH-1:0] pe_a_q, pe_a_d;
    logic              pe_valid_q, pe_valid_d;

    // Row window is [ROW, ROW+K_LEN-1]; CW holds ROW+K_LEN without wrapping.
    assign end_excl = ROW_C + CW'(k_len_i);
    assign due_o    = run_i && (t_i >= ROW_C) && (t_i < end_excl);

    always_comb begin
        pe_a_d     = pe_a_q;
        pe_valid_d = pe_valid_q;
        if (clear_i) begin
            pe_a_d     = '0;
            pe_valid_d = 1'b0;
        end else if (advance_i) begin
            pe_a_d     = due_o ? dout_i : '0;
            pe_valid_d = due_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pe_a_q     <= '0;
            pe_valid_q <= 1'b0;
        end else begin
            pe_a_q     <= pe_a_d;
            pe_valid_q <= pe_valid_d;
        end
    end

    assign pe_a_o     = pe_a_q;
    assign pe_valid_o = pe_valid_q;
endmodule

// File: rtl/systolic_row_feeder.sv
// Skewing feeder: pops each row FIFO K_LEN times with row r lagging row 0 by r steps,
// stalling every row together whenever any due row's FIFO is empty.
module systolic_row_feeder
    import systolic_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   START,
    input  logic [KW-1:0]          K_LEN,
    input  logic [ROWS-1:0]        FIFO_EMPTY,
    input  logic [ROWS*BWIDTH-1:0] FIFO_DOUT,
    output logic [ROWS-1:0]        FIFO_POPE,
    output logic [ROWS*BWIDTH-1:0] PE_A,
    output logic [ROWS-1:0]        PE_VALID,
    output logic                   ARRAY_EN,
    output logic                   BUSY,
    output logic                   DONE,
    output feeder_state_e          DBG_STATE
);
    localparam logic [CW-1:0] LAST_T_BASE = CW'(ROWS - 2);

    feeder_state_e   state_q;
    logic [CW-1:0]   t_q;
    logic [KW-1:0]   k_q;
    logic            array_en_q;

    logic            run;
    logic            clear;
    logic            stall;
    logic            advance;
    logic            last_t;
    logic [ROWS-1:0] due;

    assign run     = (state_q == ST_RUN);
    assign clear   = (state_q == ST_DONE);
    assign stall   = |(due & FIFO_EMPTY);
    assign advance = run && !stall;
    assign last_t  = (t_q == (CW'(k_q) + LAST_T_BASE));

    // Pops only on an advance, so a due row with an empty FIFO blocks all pops.
    assign FIFO_POPE = advance ? due : '0;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        systolic_feeder_lane #(.ROW(r)) u_lane (
            .clk_i      (CLK),
            .rst_ni     (RSTn),
            .run_i      (run),
            .t_i        (t_q),
            .k_len_i    (k_q),
            .advance_i  (advance),
            .clear_i    (clear),
            .dout_i     (FIFO_DOUT[r*BWIDTH +: BWIDTH]),
            .due_o      (due[r]),
            .pe_a_o     (PE_A[r*BWIDTH +: BWIDTH]),
            .pe_valid_o (PE_VALID[r])
        );
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            t_q        <= '0;
            k_q        <= '0;
            array_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    array_en_q <= 1'b0;
                    if (START) begin
                        k_q     <= K_LEN;
                        t_q     <= '0;
                        state_q <= (K_LEN == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    array_en_q <= advance;
                    if (advance) begin
                        t_q <= t_q + 1'b1;
                        if (last_t) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    array_en_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    array_en_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ARRAY_EN  = array_en_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = (state_q == ST_DONE);
    assign DBG_STATE = state_q;
endmodule

// File: tb/tb_systolic_row_feeder.sv
// Bench for systolic_row_feeder: FIFO models feed the DUT, popped operands go into per-row
// expected queues and are compared when the array advances.
`timescale 1ns/1ps
module tb_systolic_row_feeder;
    import systolic_pkg::*;

    localparam int W = BWIDTH;

    logic                CLK = 1'b0;
    logic                RSTn = 1'b0;
    logic                START = 1'b0;
    logic [KW-1:0]       K_LEN = '0;
    logic [ROWS-1:0]     FIFO_EMPTY;
    logic [ROWS*W-1:0]   FIFO_DOUT;
    logic [ROWS-1:0]     FIFO_POPE;
    logic [ROWS*W-1:0]   PE_A;
    logic [ROWS-1:0]     PE_VALID;
    logic                ARRAY_EN;
    logic                BUSY;
    logic                DONE;
    feeder_state_e       DBG_STATE;

    int total = 0;
    int bad = 0;

    logic [W-1:0]    fifo_q [ROWS][$];
    logic [W-1:0]    exp_q  [ROWS][$];
    int              pop_cnt [ROWS];
    logic [ROWS-1:0] stall_mask = '0;

    logic [ROWS-1:0] pop_s, empty_s;
    logic [ROWS-1:0] vhist [$];
    logic [ROWS*W-1:0] ahist [$];
    int              done_cyc, done_cnt, en_low_cnt;
    bit              timed_out;
    logic [ROWS-1:0] pope_stall;
    logic [ROWS*W-1:0] snap_a, hold_a;
    logic [ROWS-1:0] snap_v, hold_v;

    systolic_row_feeder dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .START      (START),
        .K_LEN      (K_LEN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_DOUT  (FIFO_DOUT),
        .FIFO_POPE  (FIFO_POPE),
        .PE_A       (PE_A),
        .PE_VALID   (PE_VALID),
        .ARRAY_EN   (ARRAY_EN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .DBG_STATE  (DBG_STATE)
    );

    always #5 CLK = ~CLK;

    task automatic update_fifo_io();
        for (int r = 0; r < ROWS; r++) begin
            FIFO_EMPTY[r] = (fifo_q[r].size() == 0) || stall_mask[r];
            FIFO_DOUT[r*W +: W] = (fifo_q[r].size() == 0) ? '0 : fifo_q[r][0];
        end
    endtask

    function automatic logic [ROWS-1:0] diag(input int a, input int k);
        logic [ROWS-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[r] = (r <= a) && (a <= r + k - 1);
        return v;
    endfunction

    // FIFO model + scoreboard: pops seen at the edge feed exp_q, advances drain it.
    always @(posedge CLK) begin
        pop_s = FIFO_POPE;
        empty_s = FIFO_EMPTY;
        #1;
        for (int r = 0; r < ROWS; r++) begin
            if (pop_s[r]) begin
                total++;
                if (empty_s[r] || fifo_q[r].size() == 0) begin
                    bad++;
                    $display("FAIL pop_on_empty row=%0d got=pop exp=no_pop", r);
                end else begin
                    exp_q[r].push_back(fifo_q[r].pop_front());
                    pop_cnt[r]++;
                end
            end
        end
        if (ARRAY_EN) begin
            for (int r = 0; r < ROWS; r++) begin
                total++;
                if (PE_VALID[r]) begin
                    if (exp_q[r].size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_valid row=%0d got=%0h exp=none", r, PE_A[r*W +: W]);
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q[r].pop_front();
                        if (PE_A[r*W +: W] !== e) begin
                            bad++;
                            $display("FAIL operand row=%0d got=%0h exp=%0h", r, PE_A[r*W +: W], e);
                        end
                    end
                end else if (PE_A[r*W +: W] !== '0) begin
                    bad++;
                    $display("FAIL idle_operand row=%0d got=%0h exp=0", r, PE_A[r*W +: W]);
                end
            end
        end
        update_fifo_io();
    end

    task automatic preload(input int n, input bit rnd);
        for (int r = 0; r < ROWS; r++) begin
            fifo_q[r].delete();
            exp_q[r].delete();
            pop_cnt[r] = 0;
            for (int j = 0; j < n; j++)
                fifo_q[r].push_back(rnd ? W'($urandom_range(0, 255)) : W'(10 * r + j + 1));
        end
        update_fifo_io();
    endtask

    task automatic issue_start(input int k);
        @(negedge CLK);
        START = 1'b1;
        K_LEN = KW'(k);
    endtask

    // Collects observations of one pass; cycle 1 is the first cycle after the START edge.
    task automatic watch_pass(input int budget, input int st_from, input int st_len,
                              input logic [ROWS-1:0] st_m, input bit rand_st, input int restart_at);
        int cyc;
        cyc = 0;
        vhist.delete();
        ahist.delete();
        done_cyc = -1;
        done_cnt = 0;
        en_low_cnt = 0;
        timed_out = 0;
        pope_stall = '0;
        while (1) begin
            @(negedge CLK);
            cyc++;
            if (cyc == 1) START = 1'b0;
            if (cyc == restart_at) begin
                START = 1'b1;
                K_LEN = KW'(7);
            end else if (cyc == restart_at + 1) begin
                START = 1'b0;
            end
            if (ARRAY_EN) begin
                vhist.push_back(PE_VALID);
                ahist.push_back(PE_A);
            end else if (BUSY && !DONE && vhist.size() > 0) begin
                en_low_cnt++;
            end
            if (DONE) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (st_len > 0 && cyc == st_from + 1) begin
                snap_a = PE_A;
                snap_v = PE_VALID;
            end
            if (st_len > 0 && cyc == st_from + 2) begin
                hold_a = PE_A;
                hold_v = PE_VALID;
            end
            if (st_len > 0 && cyc == st_from) stall_mask = st_m;
            if (st_len > 0 && cyc == st_from + st_len) stall_mask = '0;
            if (rand_st)
                stall_mask = ($urandom_range(0, 3) == 0) ? (ROWS'(1) << $urandom_range(0, ROWS - 1)) : '0;
            update_fifo_io();
            #1;
            if (st_len > 0 && stall_mask != '0) pope_stall |= FIFO_POPE;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
        end
        stall_mask = '0;
        update_fifo_io();
    endtask

    task automatic check_pass_common(input string name, input int k, input int exp_done);
        total++;
        if (timed_out !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout got=%0d exp=0", name, timed_out);
        end
        total++;
        if (done_cyc !== exp_done) begin
            bad++;
            $display("FAIL %s_done_cycle got=%0d exp=%0d", name, done_cyc, exp_done);
        end
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL %s_done_count got=%0d exp=1", name, done_cnt);
        end
        total++;
        if (vhist.size() !== ((k == 0) ? 0 : k + ROWS - 1)) begin
            bad++;
            $display("FAIL %s_advances got=%0d exp=%0d", name, vhist.size(), (k == 0) ? 0 : k + ROWS - 1);
        end
        for (int a = 0; a < vhist.size(); a++) begin
            total++;
            if (vhist[a] !== diag(a, k)) begin
                bad++;
                $display("FAIL %s_skew adv=%0d got=%0h exp=%0h", name, a, vhist[a], diag(a, k));
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (pop_cnt[r] !== k || exp_q[r].size() !== 0) begin
                bad++;
                $display("FAIL %s_pops row=%0d got=%0d exp=%0d", name, r, pop_cnt[r], k);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        total += 7;
        if (PE_VALID !== '0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", PE_VALID); end
        if (PE_A !== '0) begin bad++; $display("FAIL reset_pe_a got=%0h exp=0", PE_A); end
        if (ARRAY_EN !== 1'b0) begin bad++; $display("FAIL reset_array_en got=%0b exp=0", ARRAY_EN); end
        if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", BUSY); end
        if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", DONE); end
        if (FIFO_POPE !== '0) begin bad++; $display("FAIL reset_pope got=%0h exp=0", FIFO_POPE); end
        if (DBG_STATE !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=0", DBG_STATE); end
        RSTn = 1'b1;
    endtask

    task automatic test_basic();
        preload(3, 0);
        issue_start(3);
        watch_pass(400, 0, 0, '0, 0, 0);
        check_pass_common("basic", 3, 3 + ROWS);
        total++;
        if (en_low_cnt !== 0) begin bad++; $display("FAIL basic_stalls got=%0d exp=0", en_low_cnt); end
        for (int a = 0; a < ahist.size(); a++)
            for (int r = 0; r < ROWS; r++)
                if (a >= r && a <= r + 2) begin
                    total++;
                    if (ahist[a][r*W +: W] !== W'(10 * r + (a - r) + 1)) begin
                        bad++;
                        $display("FAIL basic_data row=%0d adv=%0d got=%0d exp=%0d", r, a,
                                 ahist[a][r*W +: W], W'(10 * r + (a - r) + 1));
                    end
                end
    endtask

    task automatic test_stall();
        preload(3, 0);
        issue_start(3);
        watch_pass(400, 3, 2, ROWS'(4), 0, 0);
        check_pass_common("stall", 3, 3 + ROWS + 2);
        total += 4;
        if (en_low_cnt !== 2) begin bad++; $display("FAIL stall_en_low got=%0d exp=2", en_low_cnt); end
        if (pope_stall !== '0) begin bad++; $display("FAIL stall_pope got=%0h exp=0", pope_stall); end
        if (hold_a !== snap_a) begin bad++; $display("FAIL stall_hold_a got=%0h exp=%0h", hold_a, snap_a); end
        if (hold_v !== snap_v) begin bad++; $display("FAIL stall_hold_v got=%0h exp=%0h", hold_v, snap_v); end
    endtask

    task automatic test_klen_zero();
        preload(1, 0);
        issue_start(0);
        watch_pass(100, 0, 0, '0, 0, 0);
        check_pass_common("kzero", 0, 1);
        preload(0, 0);
    endtask

    task automatic test_restart();
        preload(3, 0);
        issue_start(3);
        watch_pass(400, 0, 0, '0, 0, 4);
        check_pass_common("restart", 3, 3 + ROWS);
    endtask

    task automatic test_reset_mid();
        preload(3, 0);
        issue_start(3);
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RSTn = 1'b0;
        #1;
        total += 6;
        if (PE_VALID !== '0) begin bad++; $display("FAIL rstmid_valid got=%0h exp=0", PE_VALID); end
        if (PE_A !== '0) begin bad++; $display("FAIL rstmid_pe_a got=%0h exp=0", PE_A); end
        if (ARRAY_EN !== 1'b0) begin bad++; $display("FAIL rstmid_array_en got=%0b exp=0", ARRAY_EN); end
        if (BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b exp=0", BUSY); end
        if (DONE !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%0b exp=0", DONE); end
        if (FIFO_POPE !== '0) begin bad++; $display("FAIL rstmid_pope got=%0h exp=0", FIFO_POPE); end
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++;
            if (DONE !== 1'b0 || BUSY !== 1'b0) begin
                bad++;
                $display("FAIL rstmid_held got=%0b%0b exp=00", DONE, BUSY);
            end
        end
        preload(1, 0);
        RSTn = 1'b1;
        issue_start(1);
        watch_pass(200, 0, 0, '0, 0, 0);
        check_pass_common("diag", 1, 1 + ROWS);
        for (int a = 0; a < ahist.size() && a < ROWS; a++) begin
            total++;
            if (ahist[a][a*W +: W] !== W'(10 * a + 1)) begin
                bad++;
                $display("FAIL diag_data row=%0d got=%0d exp=%0d", a, ahist[a][a*W +: W], W'(10 * a + 1));
            end
        end
    endtask

    task automatic test_long();
        preload(255, 1);
        issue_start(255);
        watch_pass(3000, 0, 0, '0, 1, 0);
        total++;
        if (timed_out !== 1'b0) begin bad++; $display("FAIL long_timeout got=%0d exp=0", timed_out); end
        total++;
        if (done_cnt !== 1) begin bad++; $display("FAIL long_done_count got=%0d exp=1", done_cnt); end
        total++;
        if (vhist.size() !== 255 + ROWS - 1) begin
            bad++;
            $display("FAIL long_advances got=%0d exp=%0d", vhist.size(), 255 + ROWS - 1);
        end
        for (int a = 0; a < vhist.size(); a++) begin
            total++;
            if (vhist[a] !== diag(a, 255)) begin
                bad++;
                $display("FAIL long_skew adv=%0d got=%0h exp=%0h", a, vhist[a], diag(a, 255));
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            total++;
            if (pop_cnt[r] !== 255 || fifo_q[r].size() !== 0 || exp_q[r].size() !== 0) begin
                bad++;
                $display("FAIL long_pops row=%0d got=%0d exp=255", r, pop_cnt[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) pop_cnt[r] = 0;
        update_fifo_io();
        test_reset();
        test_basic();
        test_stall();
        test_klen_zero();
        test_restart();
        test_reset_mid();
        test_long();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
